// File: rtl/keypad_matrix_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_matrix_scanner_if
//  Bundles the keypad pin side and the decoder side of the matrix scanner.
//  Ports carried:
//   row_n      4  matrix rows, low = key closed on the driven column
//   col_n      4  one-cold column drive
//   D0,D1      1  row index bits (D0 = MSB of key code)
//   Q0,Q1      1  column index bits
//   key_valid  1  one-cycle pulse when a new debounced key code is presented
//   key_held   1  high while the reported key remains pressed
//  master: the scanner.  slave: pins/decoder side (or a bench).
// -----------------------------------------------------------------------------
interface keypad_matrix_scanner_if;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic       D0;
   logic       D1;
   logic       Q0;
   logic       Q1;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  row_n,
      output col_n, D0, D1, Q0, Q1, key_valid, key_held
   );

   modport slave (
      output row_n,
      input  col_n, D0, D1, Q0, Q1, key_valid, key_held
   );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// keypad_matrix_scanner
//  Scans a 4x4 active-low key matrix one column at a time, debounces press and
//  release of a single key, and reports the key as {D0,D1,Q0,Q1} = {row,col}
//  together with a one-cycle key_valid pulse per debounced press.
//  Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   kp     keypad_matrix_scanner_if.master (row_n in; col_n, D0, D1, Q0, Q1,
//          key_valid, key_held out)
//  Parameters:
//   SCAN_DIV         clocks each column is driven before rows are sampled (>=4)
//   DEBOUNCE_CYCLES  consecutive stable clocks for press and release (>=2)
// -----------------------------------------------------------------------------
module keypad_matrix_scanner #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic                           clk,
   input  logic                           rst_n,
   keypad_matrix_scanner_if.master        kp
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   state_t           state, state_nxt;
   logic [3:0]       row_meta, row_s;
   logic [1:0]       col, col_nxt;
   logic [DIV_W-1:0] div, div_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       r, r_nxt;
   logic [3:0]       code, code_nxt;
   logic             key_valid, valid_nxt;
   logic             key_held, held_nxt;
   logic             row_open;

   // Lowest-indexed closed row wins when several rows read low together.
   function automatic logic [1:0] lowest_low(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd3;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // Only the latched row is watched once a key is being tracked.
   assign row_open = row_s[r];

   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      div_nxt   = div;
      cnt_nxt   = cnt;
      r_nxt     = r;
      code_nxt  = code;
      valid_nxt = 1'b0;
      held_nxt  = key_held;
      case (state)
         SCAN: begin
            if (div == DIV_LAST) begin
               div_nxt = '0;
               if (row_s != 4'hF) begin
                  r_nxt     = lowest_low(row_s);
                  cnt_nxt   = '0;
                  state_nxt = DEBOUNCE;
               end else begin
                  col_nxt = col + 2'd1;
               end
            end else begin
               div_nxt = div + DIV_W'(1);
            end
         end
         DEBOUNCE: begin
            if (row_open) begin
               // Bounce: retry on the same column from a fresh dwell.
               cnt_nxt   = '0;
               div_nxt   = '0;
               state_nxt = SCAN;
            end else if (cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               code_nxt  = {r, col};
               valid_nxt = 1'b1;
               held_nxt  = 1'b1;
               state_nxt = HELD;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (row_open) begin
               cnt_nxt   = '0;
               state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            if (!row_open) begin
               cnt_nxt   = '0;
               state_nxt = HELD;
            end else if (cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               div_nxt   = '0;
               col_nxt   = col + 2'd1;
               held_nxt  = 1'b0;
               state_nxt = SCAN;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= SCAN;
         row_meta  <= 4'hF;
         row_s     <= 4'hF;
         col       <= 2'd0;
         div       <= '0;
         cnt       <= '0;
         r         <= 2'd0;
         code      <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         // Two-stage synchroniser for the asynchronous row pins.
         row_meta  <= kp.row_n;
         row_s     <= row_meta;
         state     <= state_nxt;
         col       <= col_nxt;
         div       <= div_nxt;
         cnt       <= cnt_nxt;
         r         <= r_nxt;
         code      <= code_nxt;
         key_valid <= valid_nxt;
         key_held  <= held_nxt;
      end
   end

   assign kp.col_n     = ~(4'b0001 << col);
   assign kp.D0        = code[3];
   assign kp.D1        = code[2];
   assign kp.Q0        = code[1];
   assign kp.Q1        = code[0];
   assign kp.key_valid = key_valid;
   assign kp.key_held  = key_held;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_matrix_scanner
//  Bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8. A key
//  model pulls the selected rows low only while its column is driven. Expected
//  key codes are queued when a press is applied and compared on key_valid.
// -----------------------------------------------------------------------------
module tb_keypad_matrix_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;

   logic clk;
   logic rst_n;

   keypad_matrix_scanner_if kif();

   keypad_matrix_scanner #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kif.master)
   );

   // Key model
   logic       pressed;
   logic [1:0] key_col;
   logic [3:0] rowmask;

   assign kif.row_n = (pressed && (kif.col_n[key_col] == 1'b0)) ? ~rowmask : 4'hF;

   logic [3:0] code_now;
   assign code_now = {kif.D0, kif.D1, kif.Q0, kif.Q1};

   int n_chk = 0;
   int n_err = 0;
   int pulse_cnt = 0;
   logic [3:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard / monitor, sampled on the falling edge.
   logic [3:0] code_prev;
   logic       rst_prev = 1'b0;
   always @(negedge clk) begin
      if (rst_n && kif.key_valid) begin
         pulse_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'(exp_q.size()), 32'd1);
         end else begin
            check("key_code", 32'(code_now), 32'(exp_q.pop_front()));
         end
         check("held_at_pulse", 32'(kif.key_held), 32'd1);
      end else if (rst_n && rst_prev && code_now !== code_prev) begin
         check("dq_stable", 32'(code_now), 32'(code_prev));
      end
      code_prev = code_now;
      rst_prev  = rst_n;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [1:0] c, input logic [3:0] rows);
      key_col = c;
      rowmask = rows;
      pressed = 1'b1;
   endtask

   task automatic wait_pulse(input string tag, input int budget);
      int start;
      start = pulse_cnt;
      for (int i = 0; i < budget && pulse_cnt == start; i++) tick(1);
      check(tag, 32'(pulse_cnt - start), 32'd1);
   endtask

   task automatic wait_release(input int budget, output int cycles);
      cycles = 0;
      while (kif.key_held && cycles < budget) begin
         tick(1);
         cycles++;
      end
   endtask

   function automatic logic [3:0] cold(input int c);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << c);
   endfunction

   initial begin
      int cyc;
      rst_n   = 1'b0;
      pressed = 1'b0;
      key_col = 2'd0;
      rowmask = 4'h0;

      // Reset values
      tick(2);
      check("rst_col_n", 32'(kif.col_n), 32'hE);
      check("rst_code", 32'(code_now), 32'h0);
      check("rst_valid", 32'(kif.key_valid), 32'd0);
      check("rst_held", 32'(kif.key_held), 32'd0);

      // Idle scan: each column for SCAN_DIV clocks
      rst_n = 1'b1;
      for (int k = 1; k < 20; k++) begin
         tick(1);
         check("idle_col_n", 32'(kif.col_n), 32'(cold((k / SCAN_DIV) % 4)));
      end

      // Clean press row2/col1
      exp_q.push_back({2'd2, 2'd1});
      press(2'd1, 4'b0100);
      wait_pulse("press_pulse", 100);
      check("press_held", 32'(kif.key_held), 32'd1);
      tick(20);
      check("press_no_repeat", 32'(pulse_cnt), 32'd1);
      check("press_col_frozen", 32'(kif.col_n), 32'hD);
      pressed = 1'b0;
      wait_release(50, cyc);
      check("rel1_held", 32'(kif.key_held), 32'd0);
      check("rel1_next_col", 32'(kif.col_n), 32'hB);

      // Bouncing press: low 5, high 1, never long enough to debounce
      key_col = 2'd1;
      rowmask = 4'b0100;
      for (int i = 0; i < 8; i++) begin
         pressed = 1'b1;
         tick(5);
         pressed = 1'b0;
         tick(1);
      end
      check("bounce_no_pulse", 32'(pulse_cnt), 32'd1);
      exp_q.push_back({2'd2, 2'd1});
      pressed = 1'b1;
      wait_pulse("bounce_pulse", 100);

      // Long hold then bouncing release
      tick(100);
      check("hold_no_repeat", 32'(pulse_cnt), 32'd2);
      check("hold_held", 32'(kif.key_held), 32'd1);
      for (int i = 0; i < 2; i++) begin
         pressed = 1'b0;
         tick(3);
         pressed = 1'b1;
         tick(2);
      end
      pressed = 1'b0;
      wait_release(50, cyc);
      // 2 synchroniser stages + 1 clock to enter RELEASE + DEB clocks
      check("release_latency", 32'(cyc), 32'(DEB + 3));
      check("release_next_col", 32'(kif.col_n), 32'hB);
      check("release_no_pulse", 32'(pulse_cnt), 32'd2);

      // Two rows closed on col2: lowest row (1) wins
      exp_q.push_back({2'd1, 2'd2});
      press(2'd2, 4'b1010);
      wait_pulse("multi_pulse", 100);
      pressed = 1'b0;
      wait_release(50, cyc);
      check("multi_released", 32'(kif.key_held), 32'd0);

      // Reset while HELD
      exp_q.push_back({2'd3, 2'd3});
      press(2'd3, 4'b1000);
      wait_pulse("k33_pulse", 100);
      check("k33_held", 32'(kif.key_held), 32'd1);
      rst_n = 1'b0;
      tick(1);
      check("hrst_col_n", 32'(kif.col_n), 32'hE);
      check("hrst_code", 32'(code_now), 32'h0);
      check("hrst_valid", 32'(kif.key_valid), 32'd0);
      check("hrst_held", 32'(kif.key_held), 32'd0);
      pressed = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      check("post_rst_col_n", 32'(kif.col_n), 32'hE);
      tick(30);
      check("post_rst_no_pulse", 32'(pulse_cnt), 32'd4);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
